// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: default datapath widths, NOP encoding and
// the IF/ID occupancy states.
package mips_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int PC_W_DEF    = 32;
  localparam int PC_STEP_DEF = 4;
  localparam int CNT_W_DEF   = 16;

  // sll $0,$0,0
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One IF/ID storage slot: {instr, pc, pc_next} captured together on load_i.
module pipe_entry #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [PC_W-1:0]    pc_next_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_next_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_next_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q   <= '0;
      pc_q      <= '0;
      pc_next_q <= '0;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pc_q      <= pc_i;
      pc_next_q <= pc_next_i;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pc_next_o = pc_next_q;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: two-entry skid buffer with registered in_ready,
// synchronous flush to a NOP bubble and a saturating stall counter.
module if_id_pipe
  import mips_pkg::*;
#(
  parameter int                 INSTR_W = INSTR_W_DEF,
  parameter int                 PC_W    = PC_W_DEF,
  parameter int                 PC_STEP = PC_STEP_DEF,
  parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(MIPS_NOP),
  parameter int                 CNT_W   = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_next,
  output logic [CNT_W-1:0]   stall_cnt
);

  pipe_state_e        state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic               in_xfer, out_xfer;
  logic               load_main, load_skid, main_from_skid;
  logic [PC_W-1:0]    in_pc_next;

  logic [INSTR_W-1:0] main_instr_d, main_instr, skid_instr;
  logic [PC_W-1:0]    main_pc_d, main_pc, skid_pc;
  logic [PC_W-1:0]    main_pc_next_d, main_pc_next, skid_pc_next;

  assign in_pc_next = in_pc + PC_W'(PC_STEP);
  assign out_valid  = (state_q != EMPTY);
  assign in_xfer    = in_valid & in_ready_q;
  assign out_xfer   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              state_d   = TWO;
              load_skid = 1'b1;
            end
            2'b01: state_d = EMPTY;
            2'b11: load_main = 1'b1;
            default: state_d = ONE;
          endcase
        end
        TWO: begin
          // in_ready is low here, so only the drain of main can happen
          if (out_xfer) begin
            state_d        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign in_ready_d = (state_d != TWO);

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign main_instr_d   = main_from_skid ? skid_instr   : in_instr;
  assign main_pc_d      = main_from_skid ? skid_pc      : in_pc;
  assign main_pc_next_d = main_from_skid ? skid_pc_next : in_pc_next;

  pipe_entry #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_main (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_i    (load_main),
    .instr_i   (main_instr_d),
    .pc_i      (main_pc_d),
    .pc_next_i (main_pc_next_d),
    .instr_o   (main_instr),
    .pc_o      (main_pc),
    .pc_next_o (main_pc_next)
  );

  pipe_entry #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_i    (load_skid),
    .instr_i   (in_instr),
    .pc_i      (in_pc),
    .pc_next_i (in_pc_next),
    .instr_o   (skid_instr),
    .pc_o      (skid_pc),
    .pc_next_o (skid_pc_next)
  );

  assign in_ready    = in_ready_q;
  assign out_instr   = out_valid ? main_instr   : NOP;
  assign out_pc      = out_valid ? main_pc      : '0;
  assign out_pc_next = out_valid ? main_pc_next : '0;
  assign stall_cnt   = stall_q;

endmodule
